spi_mem_slave: RTL and testbench
================================

// Module: spi_mem_slave
// PURPOSE
//  Parametrised SPI slave with an integrated synchronous memory. One SS_n-framed
//  command per transaction: write address, write data, read address or read data.
//  Generalises the fixed 8-bit SPI+RAM pair to any address/data width.
//  Optional address auto-increment enables sequential burst access.
//  Sits at chip top as the host-visible register/scratch store.
// PARAMETERS
//  ADDR_W  8  memory address width; DEPTH = 2**ADDR_W words (localparam)
//  DATA_W  8  memory word width; also the MISO read-out length in bits
// PORTS
//  clk    in   1  single system clock; also the SPI bit clock (MOSI sampled on rising edge)
//  rst    in   1  asynchronous reset, active-high
//  SS_n   in   1  slave select, active-low; frames each transaction
//  MOSI   in   1  serial in, MSB first
//  MISO   out  1  serial out, MSB first; 0 when not shifting
//  busy   out  1  high from first sampled bit until return to IDLE
//  abort  out  1  one-cycle pulse when SS_n rises mid-frame (SHIFT_IN/RD_WAIT/SHIFT_OUT)
// BEHAVIOUR
//  Frame: FRAME_W = 2 + PAY_W bits, PAY_W = max(ADDR_W, DATA_W); bits[FRAME_W-1:FRAME_W-2]
//   = cmd, payload LSB-aligned, unused upper payload bits ignored.
//  cmd 00 WR_ADDR: wr_addr <= payload[ADDR_W-1:0]
//  cmd 01 WR_DATA: mem[wr_addr] <= payload[DATA_W-1:0]
//  cmd 10 RD_ADDR: rd_addr <= payload[ADDR_W-1:0]
//  cmd 11 RD_DATA: read mem[rd_addr], shift DATA_W bits out on MISO
//  Reset: state IDLE, MISO 0, busy 0, abort 0, wr_addr 0, rd_addr 0, bit counter 0;
//   memory contents NOT reset (undefined until written).
//  FSM: IDLE -> SHIFT_IN (SS_n low sampled; bit 1 captured same edge)
//   SHIFT_IN -> EXEC after FRAME_W-th bit captured at edge N
//   EXEC (cycle N+1): perform cmd; RD_DATA issues sync read -> RD_WAIT, else -> DONE
//   RD_WAIT: load shift reg from read data -> SHIFT_OUT
//   SHIFT_OUT: MISO = data[DATA_W-1] valid from edge N+3, one bit per clk, DATA_W clks -> DONE
//   DONE: ignore MOSI, MISO 0, until SS_n high -> IDLE
//  One command per SS_n assertion; extra bits after a completed frame are discarded.
//  SS_n high in any state: next edge -> IDLE, counter cleared, MISO 0. If mid-frame:
//   no memory write, no address update, abort pulse. SS_n high in EXEC: cmd still executes.
//  Write and read address registers are independent; RD_DATA with no prior RD_ADDR uses 0.
//  rst asserted mid-transaction: immediate return to reset values; master must re-frame.
// CONFIGURATION
//  SPI_MEM_AUTOINC_EN defined: after WR_DATA wr_addr <= wr_addr+1, after RD_DATA issue
//   rd_addr <= rd_addr+1, both modulo DEPTH (DEPTH-1 wraps to 0).
//  Not defined: addresses change only via WR_ADDR / RD_ADDR.
// STRUCTURE
//  Package spi_mem_pkg: cmd enum {WR_ADDR, WR_DATA, RD_ADDR, RD_DATA}, state enum
//   {IDLE, SHIFT_IN, EXEC, RD_WAIT, SHIFT_OUT, DONE}, function frame_w(ADDR_W, DATA_W).
//  Sub-module spi_mem_array: DEPTH x DATA_W simple dual-port, 1 write port, 1 registered
//   read port (1-cycle latency), no reset. FSM, shifters, counters and address regs in top.
// TESTING (ADDR_W=8, DATA_W=8 unless stated)
//  1 WR_ADDR 0x3C, WR_DATA 0xA5, RD_ADDR 0x3C, RD_DATA -> MISO = 1010_0101 from edge N+3.
//  2 AUTOINC_EN: WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22; RD_ADDR 0xFF, 2x RD_DATA
//     -> 0x11 then 0x22 (mem[0x00]); without macro -> 0x22 twice, mem[0x00] unchanged.
//  3 WR_ADDR 0x10, WR_DATA 0x77, then WR_DATA frame with SS_n high after 5 bits -> abort
//     pulse 1 clk, RD 0x10 returns 0x77.
//  4 Frame of 14 bits with SS_n held low -> last 4 bits ignored, state DONE, MISO 0.
//  5 ADDR_W=10, DATA_W=16: WR_ADDR 0x3FF, WR_DATA 0xBEEF, read back -> 16-bit 0xBEEF.
//  6 rst pulse during SHIFT_OUT -> MISO 0, busy 0 same cycle; new RD_DATA reads mem[0].

Source files
------------

// File: rtl/spi_mem_pkg.sv
// Shared command/state types and the frame-width helper for the SPI memory slave.
package spi_mem_pkg;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        EXEC,
        RD_WAIT,
        SHIFT_OUT,
        DONE
    } state_e;

    // Two command bits followed by a payload wide enough for either an address or a data word.
    function automatic int frame_w(input int addr_w, input int data_w);
        return 2 + ((addr_w > data_w) ? addr_w : data_w);
    endfunction

endpackage

// File: rtl/spi_mem_array.sv
// DEPTH x DATA_W simple dual-port RAM: one write port, one registered read port (1-cycle latency).
module spi_mem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array and its read register have no reset so they map onto block RAM;
    // contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/spi_mem_slave.sv
// SPI slave fronting a synchronous word memory: one 2-bit command plus payload per SS_n frame.
// Build option: define SPI_MEM_AUTOINC_EN for post-access address auto-increment.
module spi_mem_slave
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic busy,
    output logic abort
);

    localparam int DEPTH   = 2**ADDR_W;
    localparam int PAY_W   = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int CNT_W   = $clog2(FRAME_W);

`ifdef SPI_MEM_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    state_e             state;
    state_e             state_nxt;
    logic [FRAME_W-1:0] sh_in;
    logic [DATA_W-1:0]  sh_out;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  wr_addr;
    logic [ADDR_W-1:0]  rd_addr;
    logic               abort_q;

    logic               capture;
    logic               cnt_inc;
    logic               cnt_clr;
    logic               exec;
    logic               load_out;
    logic               shift_out;
    logic               abort_set;
    logic               last_in;
    logic               last_out;

    logic               mem_we;
    logic               mem_re;
    logic [DATA_W-1:0]  mem_rdata;

    cmd_e               cmd;
    logic [PAY_W-1:0]   payload;

    assign cmd      = cmd_e'(sh_in[FRAME_W-1 -: 2]);
    assign payload  = sh_in[PAY_W-1:0];
    assign last_in  = (cnt == CNT_W'(FRAME_W - 1));
    assign last_out = (cnt == CNT_W'(DATA_W - 1));

    assign mem_we = exec && (cmd == WR_DATA);
    assign mem_re = exec && (cmd == RD_DATA);

    assign MISO  = (state == SHIFT_OUT) && sh_out[DATA_W-1];
    assign busy  = (state != IDLE);
    assign abort = abort_q;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values;
    // blocking assignments here would create order-dependent simulation races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;
        exec      = 1'b0;
        load_out  = 1'b0;
        shift_out = 1'b0;
        abort_set = 1'b0;

        unique case (state)
            IDLE: begin
                if (!SS_n) begin
                    capture   = 1'b1;
                    cnt_inc   = 1'b1;
                    state_nxt = SHIFT_IN;
                end
            end
            SHIFT_IN: begin
                if (SS_n) begin
                    abort_set = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    capture = 1'b1;
                    cnt_inc = 1'b1;
                    if (last_in) begin
                        cnt_clr   = 1'b1;
                        state_nxt = EXEC;
                    end
                end
            end
            EXEC: begin
                // A completed frame executes even if SS_n has already risen.
                exec = 1'b1;
                if (SS_n) begin
                    state_nxt = IDLE;
                end else if (cmd == RD_DATA) begin
                    state_nxt = RD_WAIT;
                end else begin
                    state_nxt = DONE;
                end
            end
            RD_WAIT: begin
                if (SS_n) begin
                    abort_set = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    load_out  = 1'b1;
                    state_nxt = SHIFT_OUT;
                end
            end
            SHIFT_OUT: begin
                if (SS_n) begin
                    abort_set = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    shift_out = 1'b1;
                    cnt_inc   = 1'b1;
                    if (last_out) begin
                        cnt_clr   = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (SS_n) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_in   <= '0;
            sh_out  <= '0;
            cnt     <= '0;
            wr_addr <= '0;
            rd_addr <= '0;
            abort_q <= 1'b0;
        end else begin
            abort_q <= abort_set;

            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (capture) begin
                sh_in <= {sh_in[FRAME_W-2:0], MOSI};
            end

            if (load_out) begin
                sh_out <= mem_rdata;
            end else if (shift_out) begin
                sh_out <= {sh_out[DATA_W-2:0], 1'b0};
            end

            // Address increments wrap naturally at DEPTH through the ADDR_W-bit width.
            if (exec) begin
                unique case (cmd)
                    WR_ADDR: wr_addr <= payload[ADDR_W-1:0];
                    WR_DATA: if (AUTOINC) wr_addr <= wr_addr + ADDR_W'(1);
                    RD_ADDR: rd_addr <= payload[ADDR_W-1:0];
                    RD_DATA: if (AUTOINC) rd_addr <= rd_addr + ADDR_W'(1);
                    default: ;
                endcase
            end
        end
    end

    spi_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_addr),
        .wdata (payload[DATA_W-1:0]),
        .re    (mem_re),
        .raddr (rd_addr),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_spi_mem_slave.sv
// Self-checking bench for spi_mem_slave: an 8/8 instance and a 10/16 instance against a word-level model.
module tb_spi_mem_slave;

    localparam logic [1:0] C_WA = 2'b00;
    localparam logic [1:0] C_WD = 2'b01;
    localparam logic [1:0] C_RA = 2'b10;
    localparam logic [1:0] C_RD = 2'b11;

`ifdef SPI_MEM_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic ss_a, mosi_a, miso_a, busy_a, abort_a;
    logic ss_b, mosi_b, miso_b, busy_b, abort_b;

    always #5 clk = ~clk;

    spi_mem_slave #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .SS_n  (ss_a),
        .MOSI  (mosi_a),
        .MISO  (miso_a),
        .busy  (busy_a),
        .abort (abort_a)
    );

    spi_mem_slave #(.ADDR_W(10), .DATA_W(16)) dut_w (
        .clk   (clk),
        .rst   (rst),
        .SS_n  (ss_b),
        .MOSI  (mosi_b),
        .MISO  (miso_b),
        .busy  (busy_b),
        .abort (abort_b)
    );

    int total = 0;
    int bad   = 0;

    // Word-level reference: index 0 = 8/8 instance, 1 = 10/16 instance.
    logic [15:0] m_mem   [2][1024];
    bit          m_known [2][1024];
    int          m_wa    [2];
    int          m_ra    [2];

    typedef struct {
        bit          w;
        logic [1:0]  c;
        logic [15:0] p;
        logic [15:0] e;
        bit          chk;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_wa[i] = 0;
            m_ra[i] = 0;
        end
    endtask

    task automatic model_cmd(input bit w, input logic [1:0] c, input logic [15:0] p,
                             output logic [15:0] exp, output bit known);
        int depth;
        int amask;
        int dmask;
        depth = w ? 1024 : 256;
        amask = depth - 1;
        dmask = w ? 32'hFFFF : 32'hFF;
        exp   = '0;
        known = 1'b0;
        case (c)
            C_WA: m_wa[w] = int'(p) & amask;
            C_WD: begin
                m_mem[w][m_wa[w]]   = 16'(int'(p) & dmask);
                m_known[w][m_wa[w]] = 1'b1;
                if (AUTOINC) m_wa[w] = (m_wa[w] + 1) % depth;
            end
            C_RA: m_ra[w] = int'(p) & amask;
            default: begin
                exp   = m_mem[w][m_ra[w]];
                known = m_known[w][m_ra[w]];
                if (AUTOINC) m_ra[w] = (m_ra[w] + 1) % depth;
            end
        endcase
    endtask

    task automatic send_bits(input bit w, input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            if (w) begin
                ss_b   = 1'b0;
                mosi_b = v[i];
            end else begin
                ss_a   = 1'b0;
                mosi_a = v[i];
            end
            @(posedge clk);
        end
    endtask

    task automatic end_frame(input bit w);
        @(negedge clk);
        if (w) begin
            ss_b   = 1'b1;
            mosi_b = 1'b0;
        end else begin
            ss_a   = 1'b1;
            mosi_a = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check(w ? "idle_busy_w" : "idle_busy", w ? busy_b : busy_a, 0);
    endtask

    task automatic xfer(input bit w, input logic [1:0] c, input logic [15:0] p, output logic [15:0] rd);
        int fw;
        int dw;
        logic [31:0] fr;
        fw = w ? 18 : 10;
        dw = w ? 16 : 8;
        rd = '0;
        fr = w ? {14'b0, c, p} : {22'b0, c, p[7:0]};
        send_bits(w, fr, fw);
        if (c == C_RD) begin
            @(posedge clk);
            @(posedge clk);
            for (int j = dw - 1; j >= 0; j--) begin
                @(negedge clk);
                rd[j] = w ? miso_b : miso_a;
                @(posedge clk);
            end
        end else begin
            @(posedge clk);
        end
        end_frame(w);
    endtask

    task automatic do_cmd(input bit w, input logic [1:0] c, input logic [15:0] p,
                          input bit use_exp, input logic [15:0] e, input string name);
        logic [15:0] mexp;
        logic [15:0] rd;
        bit          known;
        model_cmd(w, c, p, mexp, known);
        xfer(w, c, p, rd);
        if (c == C_RD) begin
            if (use_exp) check(name, rd, e);
            else if (known) check(name, rd, mexp);
        end
    endtask

    initial begin
        logic [15:0] mexp;
        bit          known;

        rst    = 1'b1;
        ss_a   = 1'b1;
        mosi_a = 1'b0;
        ss_b   = 1'b1;
        mosi_b = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_miso",    miso_a,  0);
        check("rst_busy",    busy_a,  0);
        check("rst_abort",   abort_a, 0);
        check("rst_miso_w",  miso_b,  0);
        check("rst_busy_w",  busy_b,  0);
        check("rst_abort_w", abort_b, 0);
        rst = 1'b0;

        // Table: preload mem[0], basic round trip, wrap/autoinc behaviour, wide instance.
        vecs.push_back('{0, C_WA, 16'h0000, 16'h0000, 0, "pre_wa"});
        vecs.push_back('{0, C_WD, 16'h005A, 16'h0000, 0, "pre_wd"});
        vecs.push_back('{0, C_WA, 16'h003C, 16'h0000, 0, "t1_wa"});
        vecs.push_back('{0, C_WD, 16'h00A5, 16'h0000, 0, "t1_wd"});
        vecs.push_back('{0, C_RA, 16'h003C, 16'h0000, 0, "t1_ra"});
        vecs.push_back('{0, C_RD, 16'h0000, 16'h00A5, 1, "t1_rd"});
        vecs.push_back('{0, C_WA, 16'h00FF, 16'h0000, 0, "t2_wa"});
        vecs.push_back('{0, C_WD, 16'h0011, 16'h0000, 0, "t2_wd1"});
        vecs.push_back('{0, C_WD, 16'h0022, 16'h0000, 0, "t2_wd2"});
        vecs.push_back('{0, C_RA, 16'h00FF, 16'h0000, 0, "t2_ra"});
        if (AUTOINC) begin
            vecs.push_back('{0, C_RD, 16'h0000, 16'h0011, 1, "t2_rd1"});
            vecs.push_back('{0, C_RD, 16'h0000, 16'h0022, 1, "t2_rd2"});
            vecs.push_back('{0, C_RA, 16'h0000, 16'h0000, 0, "t2_ra0"});
            vecs.push_back('{0, C_RD, 16'h0000, 16'h0022, 1, "t2_mem0"});
        end else begin
            vecs.push_back('{0, C_RD, 16'h0000, 16'h0022, 1, "t2_rd1"});
            vecs.push_back('{0, C_RD, 16'h0000, 16'h0022, 1, "t2_rd2"});
            vecs.push_back('{0, C_RA, 16'h0000, 16'h0000, 0, "t2_ra0"});
            vecs.push_back('{0, C_RD, 16'h0000, 16'h005A, 1, "t2_mem0"});
        end
        vecs.push_back('{1, C_WA, 16'h03FF, 16'h0000, 0, "t5_wa"});
        vecs.push_back('{1, C_WD, 16'hBEEF, 16'h0000, 0, "t5_wd"});
        vecs.push_back('{1, C_RA, 16'hFFFF, 16'h0000, 0, "t5_ra"});
        vecs.push_back('{1, C_RD, 16'h0000, 16'hBEEF, 1, "t5_rd"});

        foreach (vecs[i]) begin
            do_cmd(vecs[i].w, vecs[i].c, vecs[i].p, vecs[i].chk, vecs[i].e, vecs[i].name);
        end

        // SS_n rises after 5 bits of a WR_DATA frame: abort pulse, no write.
        do_cmd(0, C_WA, 16'h0010, 0, 16'h0, "t3_wa");
        do_cmd(0, C_WD, 16'h0077, 0, 16'h0, "t3_wd");
        send_bits(0, 32'b01101, 5);
        @(negedge clk);
        check("t3_abort_pre", abort_a, 0);
        check("t3_busy_pre",  busy_a,  1);
        ss_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t3_abort_pulse", abort_a, 1);
        check("t3_abort_busy",  busy_a,  0);
        @(posedge clk);
        @(negedge clk);
        check("t3_abort_clear", abort_a, 0);
        do_cmd(0, C_RA, 16'h0010, 0, 16'h0, "t3_ra");
        do_cmd(0, C_RD, 16'h0000, 1, 16'h0077, "t3_rd");

        // 14-bit frame: the 4 trailing bits are discarded, slave parks in DONE.
        send_bits(0, {22'b0, C_WA, 8'h20}, 10);
        model_cmd(0, C_WA, 16'h0020, mexp, known);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t4_busy", busy_a, 1);
            check("t4_miso", miso_a, 0);
            mosi_a = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        check("t4_done_busy", busy_a, 1);
        check("t4_done_miso", miso_a, 0);
        end_frame(0);
        do_cmd(0, C_WD, 16'h0099, 0, 16'h0, "t4_wd");
        do_cmd(0, C_RA, 16'h0020, 0, 16'h0, "t4_ra");
        do_cmd(0, C_RD, 16'h0000, 1, 16'h0099, "t4_rd");

        // Reset pulse during SHIFT_OUT, then RD_DATA with the read address back at 0.
        do_cmd(0, C_RA, 16'h003C, 0, 16'h0, "t6_ra");
        send_bits(0, {22'b0, C_RD, 8'h00}, 10);
        model_cmd(0, C_RD, 16'h0000, mexp, known);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("t6_miso_pre", miso_a, mexp[7]);
        check("t6_busy_pre", busy_a, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_miso",  miso_a,  0);
        check("t6_rst_busy",  busy_a,  0);
        check("t6_rst_abort", abort_a, 0);
        @(posedge clk);
        @(negedge clk);
        ss_a   = 1'b1;
        mosi_a = 1'b0;
        rst    = 1'b0;
        model_reset();
        @(posedge clk);
        do_cmd(0, C_RD, 16'h0000, 0, 16'h0, "t6_rd_mem0");

        // Randomized traffic over a small address window so reads usually hit written words.
        for (int a = 0; a < 8; a++) begin
            for (int w = 0; w < 2; w++) begin
                do_cmd(w[0], C_WA, 16'(a), 0, 16'h0, "rnd_pre_wa");
                do_cmd(w[0], C_WD, 16'($urandom), 0, 16'h0, "rnd_pre_wd");
            end
        end
        for (int n = 0; n < 80; n++) begin
            bit          w;
            logic [1:0]  c;
            logic [15:0] p;
            w = 1'($urandom_range(0, 1));
            c = 2'($urandom_range(0, 3));
            if (c == C_WA || c == C_RA) begin
                p = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
            end else begin
                p = 16'($urandom);
            end
            do_cmd(w, c, p, 0, 16'h0, w ? "rnd_rd_w" : "rnd_rd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
